// File: rtl/writeback_stage_if.sv
// writeback_stage_if: memory-stage inputs, register-file read ports and writeback/forward outputs
interface writeback_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              valid_in;
    logic [DATA_W-1:0] result_alu_in;
    logic [DATA_W-1:0] mem_out_in;
    logic [ADDR_W-1:0] dir_wb_in;
    logic              reg_wr_in;
    logic              sel_wb;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dir;
    logic [DATA_W-1:0] wb_data;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_dir;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  retired_count;

    modport master (
        output stall, flush, valid_in, result_alu_in, mem_out_in, dir_wb_in, reg_wr_in, sel_wb,
               rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_en, wb_dir, wb_data, fwd_valid, fwd_dir, fwd_data,
               retired_count
    );
    modport slave (
        input  stall, flush, valid_in, result_alu_in, mem_out_in, dir_wb_in, reg_wr_in, sel_wb,
               rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_en, wb_dir, wb_data, fwd_valid, fwd_dir, fwd_data,
               retired_count
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, bypassed 2**ADDR_W x DATA_W regfile, retire counter; ZERO_REG_EN hardwires r0
module writeback_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave bus
);
`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    logic              valid_q, valid_d;
    logic              reg_wr_q, reg_wr_d;
    logic              wb_done_q, wb_done_d;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rf_q [2**ADDR_W];
    logic              retire, wb_en;
    assign retire = valid_q & ~wb_done_q;
    assign wb_en  = retire & reg_wr_q & ~(ZR && dir_q == '0);
    always_comb begin
        valid_d   = valid_q;
        reg_wr_d  = reg_wr_q;
        dir_d     = dir_q;
        data_d    = data_q;
        wb_done_d = wb_done_q | retire;
        if (bus.flush) begin
            valid_d   = 1'b0;
            wb_done_d = 1'b0;
        end else if (!bus.stall) begin
            valid_d   = bus.valid_in;
            reg_wr_d  = bus.reg_wr_in;
            dir_d     = bus.dir_wb_in;
            data_d    = bus.sel_wb ? bus.mem_out_in : bus.result_alu_in;
            wb_done_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            reg_wr_q  <= 1'b0;
            wb_done_q <= 1'b0;
            dir_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) rf_q[i] <= '0;
        end else begin
            valid_q   <= valid_d;
            reg_wr_q  <= reg_wr_d;
            wb_done_q <= wb_done_d;
            dir_q     <= dir_d;
            data_q    <= data_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
            if (wb_en) rf_q[dir_q] <= data_q;
        end
    end
    assign bus.rd_data_a = (ZR && bus.rd_addr_a == '0) ? '0 :
                           (wb_en && dir_q == bus.rd_addr_a) ? data_q : rf_q[bus.rd_addr_a];
    assign bus.rd_data_b = (ZR && bus.rd_addr_b == '0) ? '0 :
                           (wb_en && dir_q == bus.rd_addr_b) ? data_q : rf_q[bus.rd_addr_b];
    assign bus.wb_en         = wb_en;
    assign bus.wb_dir        = dir_q;
    assign bus.wb_data       = data_q;
    assign bus.fwd_valid     = wb_en;
    assign bus.fwd_dir       = dir_q;
    assign bus.fwd_data      = data_q;
    assign bus.retired_count = cnt_q;
endmodule
